// File: rtl/text_writer_pkg.sv
// Shared constants, control codes and FSM encoding for the 80x50 text buffer
// (also used by the display scanner).
package text_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 50;
    localparam int TEXT_BYTES   = 4000;
    localparam int SCROLL_BYTES = TEXT_BYTES - COLS;

    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] CH_CR     = 8'h0D;

    localparam logic [6:0]  LAST_COL    = 7'd79;
    localparam logic [5:0]  LAST_ROW    = 6'd49;
    localparam logic [11:0] ROW_STRIDE  = 12'd80;
    localparam logic [11:0] SCROLL_LAST = 12'd3919;
    localparam logic [11:0] TEXT_LAST   = 12'd3999;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_SCR_RD  = 3'd2,
        ST_SCR_LAT = 3'd3,
        ST_SCR_WR  = 3'd4,
        ST_FILL    = 3'd5
    } state_e;

    // row*80 without a multiplier: row*64 + row*16.
    function automatic logic [11:0] row_base(input logic [5:0] row);
        logic [11:0] r;
        r = {6'd0, row};
        return (r << 6) + (r << 4);
    endfunction

endpackage

// File: rtl/text_writer.sv
// Character-stream writer: prints bytes into the text RAM, tracks the cursor,
// and sequences scroll-up and clear through the RAM write port.
module text_writer
    import text_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [6:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic [7:0]  byte_q, byte_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        ready_q;
    logic        busy_q;
    logic        new_line_s;

    // Next-state and next-output decode; RAM outputs are registered one cycle after the state that issues them.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        new_line_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    byte_d  = in_data;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (byte_q)
                    CH_CR: cx_d = 7'd0;
                    CH_LF: new_line_s = 1'b1;
                    CH_BS: begin
                        if (cx_q != 7'd0) begin
                            cx_d = cx_q - 7'd1;
                        end else if (cy_q != 6'd0) begin
                            cx_d = LAST_COL;
                            cy_d = cy_q - 6'd1;
                        end else begin
                            cx_d = cx_q;
                        end
                    end
                    CH_FF: begin
                        cx_d    = 7'd0;
                        cy_d    = 6'd0;
                        idx_d   = 12'd0;
                        state_d = ST_FILL;
                    end
                    default: begin
                        we_d    = 1'b1;
                        addr_d  = {5'd0, cx_q} + row_base(cy_q);
                        wdata_d = byte_q;
                        if (cx_q == LAST_COL) begin
                            new_line_s = 1'b1;
                        end else begin
                            cx_d = cx_q + 7'd1;
                        end
                    end
                endcase
                // Overflow past the bottom row keeps the cursor on row 49 and scrolls.
                if (new_line_s) begin
                    cx_d = 7'd0;
                    if (cy_q == LAST_ROW) begin
                        idx_d   = 12'd0;
                        state_d = ST_SCR_RD;
                    end else begin
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cy_d = cy_d;
                end
            end
            ST_SCR_RD: begin
                addr_d  = idx_q + ROW_STRIDE;
                state_d = ST_SCR_LAT;
            end
            ST_SCR_LAT: state_d = ST_SCR_WR;
            ST_SCR_WR: begin
                we_d    = 1'b1;
                addr_d  = idx_q;
                wdata_d = mem_rdata;
                idx_d   = idx_q + 12'd1;
                if (idx_q == SCROLL_LAST) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_SCR_RD;
                end
            end
            ST_FILL: begin
                we_d    = 1'b1;
                addr_d  = idx_q;
                wdata_d = FILL_CHAR;
                if (idx_q == TEXT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            default: begin
                idx_d   = 12'd0;
                state_d = ST_FILL;
            end
        endcase
    end

    // State, cursor and output registers; reset restarts a full clear from address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FILL;
            idx_q   <= 12'd0;
            cx_q    <= 7'd0;
            cy_q    <= 6'd0;
            byte_q  <= 8'd0;
            addr_q  <= 12'd0;
            wdata_q <= FILL_CHAR;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;

endmodule
